// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-queue block: serializer state encoding,
// parity mode constants and the payload parity helper.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

   // Parity over the low nbits of data; odd mode inverts the even result.
   function automatic logic frame_parity(input logic [7:0] data,
                                         input int unsigned nbits,
                                         input int mode);
      logic p;
      p = 1'b0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (i < nbits) p = p ^ data[i];
      end
      return (mode == PARITY_ODD) ? ~p : p;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered occupancy; storage is not reset, only pointers and level.
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = 1;
   localparam logic [AW:0]   LVL_ONE  = 1;
   localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      level_q, level_d;
   logic             do_push, do_pop;

   always_comb begin
      full    = (level_q == LVL_FULL);
      empty   = (level_q == '0);
      level   = level_q;
      rd_data = mem_q[rd_ptr_q];
   end

   always_comb begin
      do_push  = push && !full;
      do_pop   = pop && !empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
         2'b10:   level_d = level_q + LVL_ONE;
         2'b01:   level_d = level_q - LVL_ONE;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/uart_txq_dev.sv
// Queued UART transmitter: words enter a FIFO and are serialized as start/data/parity/stop
// frames, back-to-back while the queue holds data.
module uart_txq_dev
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          tx_valid,
   input  logic [7:0]                    tx_data,
   output logic                          tx_ready,
   output logic                          tx_o,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          tx_done
);

   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BAUD_ONE    = 1;
   localparam logic [2:0]    LAST_BIT    = 3'(DATA_BITS - 1);
   localparam logic          LAST_STOP   = 1'(STOP_BITS - 1);

   uart_state_e state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic          stop_idx_q, stop_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_q, par_d;
   logic          tx_o_q, tx_o_d;
   logic          tx_done_q, tx_done_d;

   logic          push, pop, full, empty, baud_tick;
   logic [7:0]    head;
   logic [$clog2(FIFO_DEPTH):0] level;

   uart_sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .wr_data (tx_data),
      .pop     (pop),
      .rd_data (head),
      .full    (full),
      .empty   (empty),
      .level   (level)
   );

   always_comb begin
      push       = tx_valid && !full;
      tx_ready   = !full;
      tx_o       = tx_o_q;
      tx_done    = tx_done_q;
      fifo_level = level;
      busy       = (state_q != ST_IDLE) || (level != '0);
   end

   always_comb begin
      state_d    = state_q;
      bit_idx_d  = bit_idx_q;
      stop_idx_d = stop_idx_q;
      shift_d    = shift_q;
      par_d      = par_q;
      tx_o_d     = tx_o_q;
      tx_done_d  = 1'b0;
      pop        = 1'b0;
      baud_tick  = (baud_q == '0);
      baud_d     = baud_tick ? BAUD_RELOAD : baud_q - BAUD_ONE;

      case (state_q)
         ST_IDLE: begin
            baud_d = BAUD_RELOAD;
            pop    = !empty;
         end
         ST_START: begin
            if (baud_tick) begin
               tx_o_d    = shift_q[0];
               shift_d   = {1'b0, shift_q[7:1]};
               bit_idx_d = '0;
               state_d   = ST_DATA;
            end
         end
         ST_DATA: begin
            if (baud_tick) begin
               if (bit_idx_q == LAST_BIT) begin
                  if (PARITY != PARITY_NONE) begin
                     tx_o_d  = par_q;
                     state_d = ST_PARITY;
                  end else begin
                     tx_o_d     = 1'b1;
                     stop_idx_d = 1'b0;
                     state_d    = ST_STOP;
                  end
               end else begin
                  tx_o_d    = shift_q[0];
                  shift_d   = {1'b0, shift_q[7:1]};
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         ST_PARITY: begin
            if (baud_tick) begin
               tx_o_d     = 1'b1;
               stop_idx_d = 1'b0;
               state_d    = ST_STOP;
            end
         end
         ST_STOP: begin
            if (baud_tick) begin
               if (stop_idx_q == LAST_STOP) begin
                  tx_done_d = 1'b1;
                  if (!empty) begin
                     pop = 1'b1;
                  end else begin
                     tx_o_d  = 1'b1;
                     state_d = ST_IDLE;
                  end
               end else begin
                  stop_idx_d = stop_idx_q + 1'b1;
               end
            end
         end
         default: begin
            tx_o_d  = 1'b1;
            state_d = ST_IDLE;
         end
      endcase

      // A pop always opens a new frame, whether from idle or straight out of the last stop bit.
      if (pop) begin
         state_d = ST_START;
         baud_d  = BAUD_RELOAD;
         tx_o_d  = 1'b0;
         shift_d = head;
         par_d   = frame_parity(head, DATA_BITS, PARITY);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         baud_q     <= '0;
         bit_idx_q  <= '0;
         stop_idx_q <= 1'b0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         tx_o_q     <= 1'b1;
         tx_done_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_idx_q  <= bit_idx_d;
         stop_idx_q <= stop_idx_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         tx_o_q     <= tx_o_d;
         tx_done_q  <= tx_done_d;
      end
   end

endmodule

// File: tb/tb_uart_txq_dev.sv
// Bench for uart_txq_dev: five parameterisations, line waveforms compared against frames
// rebuilt from the serial format rules (start, LSB-first data, parity, stop).
module tb_uart_txq_dev;

   localparam int NI   = 5;
   localparam int CAPN = 4096;
   localparam int CPB   [NI] = '{4, 4, 4, 4, 4};
   localparam int DBITS [NI] = '{8, 7, 7, 8, 8};
   localparam int PAR   [NI] = '{0, 1, 2, 0, 0};
   localparam int SBITS [NI] = '{1, 1, 1, 1, 2};

   logic           clk;
   logic           rst;
   logic [NI-1:0]  vld;
   logic [7:0]     dat [NI];
   wire  [NI-1:0]  rdy, txo, bsy, dne;
   wire  [4:0]     lvl0, lvl1, lvl2, lvl4;
   wire  [2:0]     lvl3;

   logic           cap_tx   [NI][CAPN];
   logic           cap_done [NI][CAPN];
   logic           cap_rdy  [NI][CAPN];
   logic           cap_busy [NI][CAPN];
   logic [4:0]     cap_lvl  [NI][CAPN];
   int             cap_n;
   int             n_assert, n_fail;
   logic [7:0]     wq [64];
   int             wn;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   uart_txq_dev #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u_dut0 (
      .clk(clk), .rst(rst), .tx_valid(vld[0]), .tx_data(dat[0]), .tx_ready(rdy[0]),
      .tx_o(txo[0]), .busy(bsy[0]), .fifo_level(lvl0), .tx_done(dne[0]));
   uart_txq_dev #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)) u_dut1 (
      .clk(clk), .rst(rst), .tx_valid(vld[1]), .tx_data(dat[1]), .tx_ready(rdy[1]),
      .tx_o(txo[1]), .busy(bsy[1]), .fifo_level(lvl1), .tx_done(dne[1]));
   uart_txq_dev #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) u_dut2 (
      .clk(clk), .rst(rst), .tx_valid(vld[2]), .tx_data(dat[2]), .tx_ready(rdy[2]),
      .tx_o(txo[2]), .busy(bsy[2]), .fifo_level(lvl2), .tx_done(dne[2]));
   uart_txq_dev #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut3 (
      .clk(clk), .rst(rst), .tx_valid(vld[3]), .tx_data(dat[3]), .tx_ready(rdy[3]),
      .tx_o(txo[3]), .busy(bsy[3]), .fifo_level(lvl3), .tx_done(dne[3]));
   uart_txq_dev #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(16)) u_dut4 (
      .clk(clk), .rst(rst), .tx_valid(vld[4]), .tx_data(dat[4]), .tx_ready(rdy[4]),
      .tx_o(txo[4]), .busy(bsy[4]), .fifo_level(lvl4), .tx_done(dne[4]));

   function automatic logic [4:0] lvl_of(input int i);
      case (i)
         0:       return lvl0;
         1:       return lvl1;
         2:       return lvl2;
         3:       return {2'b00, lvl3};
         default: return lvl4;
      endcase
   endfunction

   function automatic int frame_len(input int i);
      return (1 + DBITS[i] + ((PAR[i] != 0) ? 1 : 0) + SBITS[i]) * CPB[i];
   endfunction

   // Expected per-cycle line level for one frame; bit j is the j-th cycle after the start edge.
   function automatic logic [63:0] frame_wave(input int i, input logic [7:0] w);
      int bits [$];
      int ones, p;
      logic [63:0] v;
      ones = 0;
      bits.push_back(0);
      for (int b = 0; b < DBITS[i]; b++) begin
         bits.push_back((int'(w) >> b) & 1);
         ones += (int'(w) >> b) & 1;
      end
      if (PAR[i] == 1) bits.push_back(ones % 2);
      else if (PAR[i] == 2) bits.push_back(1 - (ones % 2));
      for (int s = 0; s < SBITS[i]; s++) bits.push_back(1);
      v = '1;
      p = 0;
      foreach (bits[k]) begin
         for (int r = 0; r < CPB[i]; r++) begin
            v[p] = bits[k][0];
            p++;
         end
      end
      return v;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock, sampling every instance on the falling edge.
   task automatic tick();
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         cap_tx[i][cap_n]   = txo[i];
         cap_done[i][cap_n] = dne[i];
         cap_rdy[i][cap_n]  = rdy[i];
         cap_busy[i][cap_n] = bsy[i];
         cap_lvl[i][cap_n]  = lvl_of(i);
      end
      if (cap_n < CAPN - 1) cap_n++;
   endtask

   // Offer wq[0..wn-1] in order on instance i for ncyc edges, pausing for edges hold_lo..hold_hi-1.
   task automatic run(input int i, input int ncyc, input int hold_lo, input int hold_hi,
                      output int accepted);
      int k;
      logic offer, r;
      k = 0;
      cap_n = 0;
      for (int c = 0; c < ncyc; c++) begin
         offer  = (k < wn) && !(c >= hold_lo && c < hold_hi);
         vld[i] = offer;
         dat[i] = offer ? wq[k] : 8'($urandom);
         r      = rdy[i];
         tick();
         if (offer && r) k++;
      end
      vld[i]   = 1'b0;
      accepted = k;
   endtask

   task automatic check_frames(input int i, input int start, input string tag, output int end_pos);
      int pos, len;
      logic [63:0] obs, exp;
      pos = start;
      len = frame_len(i);
      for (int k = 0; k < wn; k++) begin
         exp = frame_wave(i, wq[k]);
         obs = '1;
         for (int j = 0; j < len; j++) obs[j] = cap_tx[i][pos + j];
         chk($sformatf("%s line frame %0d", tag, k), obs, exp);
         chk($sformatf("%s tx_done low before end %0d", tag, k), 64'(cap_done[i][pos + len - 1]), 64'd0);
         chk($sformatf("%s tx_done at end %0d", tag, k), 64'(cap_done[i][pos + len]), 64'd1);
         pos += len;
      end
      chk($sformatf("%s mark after last frame", tag), 64'(cap_tx[i][pos]), 64'd1);
      end_pos = pos;
   endtask

   initial begin
      int acc, endp, cnt;
      logic [63:0] wave;
      n_assert = 0;
      n_fail   = 0;
      cap_n    = 0;
      wn       = 0;
      rst      = 1'b0;
      vld      = '0;
      for (int i = 0; i < NI; i++) dat[i] = 8'h00;

      #1 rst = 1'b1;
      #1;
      for (int i = 0; i < NI; i++)
         chk($sformatf("reset state u%0d", i),
             64'({txo[i], rdy[i], bsy[i], dne[i], lvl_of(i)}), 64'({1'b1, 1'b1, 1'b0, 1'b0, 5'd0}));
      tick();
      tick();
      rst = 1'b0;
      tick();
      tick();

      // Single 0xA5 frame, no parity, 4 clocks per bit.
      wn = 1;
      wq[0] = 8'hA5;
      run(0, 50, 0, 0, acc);
      chk("A5 accepted", 64'(acc), 64'd1);
      chk("A5 line still mark at acceptance", 64'(cap_tx[0][0]), 64'd1);
      chk("A5 busy after acceptance", 64'(cap_busy[0][0]), 64'd1);
      check_frames(0, 1, "A5", endp);
      chk("A5 busy clears", 64'(cap_busy[0][41]), 64'd0);
      cnt = 0;
      for (int c = 0; c < 50; c++) cnt += int'(cap_done[0][c]);
      chk("A5 single tx_done pulse", 64'(cnt), 64'd1);

      // Seven data bits with even then odd parity.
      for (int i = 1; i <= 2; i++) begin
         wn = 3;
         wq[0] = 8'h07;
         wq[1] = 8'($urandom);
         wq[2] = 8'($urandom);
         run(i, 130, 0, 0, acc);
         chk($sformatf("parity u%0d accepted", i), 64'(acc), 64'd3);
         chk($sformatf("parity bit of 0x07 u%0d", i), 64'(cap_tx[i][33]), (i == 1) ? 64'd1 : 64'd0);
         check_frames(i, 1, (i == 1) ? "even" : "odd", endp);
      end

      // Depth-4 queue with valid held high: fill, full stall, no bypass on the pop edge.
      wn = 6;
      for (int k = 0; k < 6; k++) wq[k] = {3'(k), 5'($urandom)};
      run(3, 250, 0, 0, acc);
      chk("depth4 all accepted", 64'(acc), 64'd6);
      chk("depth4 push+pop at level 1", 64'(cap_lvl[3][1]), 64'd1);
      chk("depth4 level full", 64'(cap_lvl[3][4]), 64'd4);
      cnt = 0;
      for (int c = 0; c < 250; c++) if (cap_lvl[3][c] == 5'd4 && cap_rdy[3][c]) cnt++;
      chk("depth4 tx_ready high while full", 64'(cnt), 64'd0);
      chk("depth4 no full bypass", 64'(cap_lvl[3][41]), 64'd3);
      chk("depth4 ready after pop", 64'(cap_rdy[3][41]), 64'd1);
      chk("depth4 refill", 64'(cap_lvl[3][42]), 64'd4);
      check_frames(3, 1, "depth4", endp);
      chk("depth4 idle after drain", 64'(cap_busy[3][endp]), 64'd0);

      // Two stop bits, back-to-back frames.
      wn = 3;
      for (int k = 0; k < 3; k++) wq[k] = 8'($urandom);
      run(4, 150, 0, 0, acc);
      chk("stop2 accepted", 64'(acc), 64'd3);
      cnt = 0;
      for (int c = 37; c < 45; c++) cnt += int'(cap_tx[4][c]);
      chk("stop2 mark interval", 64'(cnt), 64'd8);
      chk("stop2 next start", 64'(cap_tx[4][45]), 64'd0);
      check_frames(4, 1, "stop2", endp);

      // 48 words through a 16-deep queue, with a push landing on a pop at level 2.
      wn = 48;
      for (int k = 0; k < 48; k++) wq[k] = 8'($urandom);
      run(0, 1940, 3, 41, acc);
      chk("wrap accepted", 64'(acc), 64'd48);
      chk("wrap level before pop", 64'(cap_lvl[0][40]), 64'd2);
      chk("wrap push+pop at level 2", 64'(cap_lvl[0][41]), 64'd2);
      check_frames(0, 1, "wrap", endp);

      // Reset during data bit 3 with two words queued.
      wn = 3;
      wq[0] = 8'($urandom) & 8'hF7;
      wq[1] = 8'($urandom);
      wq[2] = 8'($urandom);
      run(0, 18, 0, 0, acc);
      wave = frame_wave(0, wq[0]);
      chk("pre-reset data bit 3", 64'(cap_tx[0][17]), 64'(wave[16]));
      chk("pre-reset level", 64'(cap_lvl[0][17]), 64'd2);
      rst = 1'b1;
      #1;
      chk("mid-frame reset tx_o", 64'(txo[0]), 64'd1);
      chk("mid-frame reset level", 64'(lvl0), 64'd0);
      chk("mid-frame reset busy", 64'(bsy[0]), 64'd0);
      chk("mid-frame reset ready", 64'(rdy[0]), 64'd1);
      chk("mid-frame reset tx_done", 64'(dne[0]), 64'd0);
      tick();
      rst = 1'b0;
      wn = 0;
      run(0, 120, 0, 0, acc);
      cnt = 0;
      for (int c = 0; c < 120; c++) if (cap_tx[0][c] !== 1'b1 || cap_done[0][c] !== 1'b0 || cap_busy[0][c] !== 1'b0) cnt++;
      chk("no activity after reset", 64'(cnt), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_txq_dev.md
UART_TXQ_DEV -- requirements
Module: uart_txq_dev

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per serial bit (minimum 2).
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame (legal range 5..8).
REQ-003 SHALL have parameter PARITY, default 0, meaning 0 = none, 1 = even, 2 = odd.
REQ-004 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame (1 or 2).
REQ-005 SHALL have parameter FIFO_DEPTH, default 16, meaning TX queue entries (power of two, at least 2).
REQ-006 SHALL have the following ports (clock and reset first):
 - clk  in  1  sole clock; all state on the rising edge.
 - rst  in  1  asynchronous, active-high reset.
 - tx_valid  in  1  producer offers tx_data.
 - tx_data  in  8  payload; only bits [DATA_BITS-1:0] are transmitted.
 - tx_ready  out  1  queue can accept a word this cycle.
 - tx_o  out  1  serial line; idle/mark = 1.
 - busy  out  1  frame in progress or queue non-empty.
 - fifo_level  out  $clog2(FIFO_DEPTH)+1  words currently queued.
 - tx_done  out  1  one-cycle pulse at the end of the last stop bit.

Function
REQ-007 SHALL accept a word at a rising edge where tx_valid && tx_ready; tx_ready SHALL equal !full, combinationally from registered state only.
REQ-008 SHALL NOT accept a word when full, even if the serializer pops in the same cycle (no full-bypass).
REQ-009 SHALL hold FSM states IDLE, START, DATA, PARITY, STOP.
REQ-010 SHALL have IDLE with fifo non-empty pop the head word into a shift register at the next edge, enter START, and drive tx_o = 0. With an empty idle block, tx_o falls one cycle after the acceptance edge.
REQ-011 SHALL hold each bit for exactly CLKS_PER_BIT cycles, using a baud counter reloaded at every bit boundary.
REQ-012 SHALL shift DATA out LSB first for DATA_BITS bits.
REQ-013 SHALL enter PARITY only when PARITY != 0. The parity bit is XOR of the payload bits for even, inverted XOR for odd.
REQ-014 SHALL drive tx_o = 1 in STOP for STOP_BITS*CLKS_PER_BIT cycles, then pulse tx_done.
REQ-015 SHALL, on leaving STOP with the queue non-empty, pop and enter START in the same edge, with no idle gap between frames; otherwise it enters IDLE.
REQ-016 SHALL keep fifo_level exact under simultaneous push and pop (level unchanged). Read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-017 SHALL assert busy whenever state != IDLE or fifo_level != 0.
REQ-018 SHALL make tx_o a register output with no combinational path from any input.

Reset
REQ-019 SHALL, while rst = 1, force tx_o = 1, state = IDLE, fifo_level = 0, tx_ready = 1, busy = 0, tx_done = 0, and clear pointers and baud counter.
REQ-020 SHALL, on reset asserted mid-frame, abort the frame immediately (asynchronously), discard all queued words, and drive the line to mark.
REQ-021 SHALL NOT reset FIFO storage contents.

Structure
REQ-022 SHALL place the FSM state encoding and the PARITY_NONE/EVEN/ODD constants in a shared package, uart_pkg.
REQ-023 SHALL instantiate one sub-module, uart_sync_fifo (parameters WIDTH, DEPTH; ports push/pop/full/empty/level). The serializer FSM stays in uart_txq_dev.

Verification
REQ-024 SHALL cover: defaults except CLKS_PER_BIT=4, PARITY=0, write 0xA5 -> tx_o low one cycle after acceptance, bits 1,0,1,0,0,1,0,1 at 4 cycles each, stop high, tx_done pulse exactly 40 cycles after the start bit begins.
REQ-025 SHALL cover: PARITY=1, DATA_BITS=7, write 0x07 -> 7 data bits 1,1,1,0,0,0,0, parity bit 1, 1 stop bit; PARITY=2 -> parity bit 0.
REQ-026 SHALL cover: FIFO_DEPTH=4, tx_valid held high with 5 distinct words from idle -> 4 accepted plus 1 once the first pop frees a slot, tx_ready low while level=4, all 5 frames emitted back-to-back with no mark gap.
REQ-027 SHALL cover: STOP_BITS=2, CLKS_PER_BIT=4 -> stop interval 8 cycles, next start bit follows immediately.
REQ-028 SHALL cover: rst pulsed during DATA bit 3 with 2 words queued -> tx_o = 1 within the same cycle, fifo_level = 0, busy = 0, no further frames emitted.
REQ-029 SHALL cover: push and pop in the same cycle at level 2 -> fifo_level stays 2, and pointer wrap-around after 3*FIFO_DEPTH words preserves data order.
